// File: rtl/simple_bus_pkg.sv
// Shared types and constants for the simple_bus arbiter slice.
package simple_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam int CMD_W_DEF = 4;
  localparam logic [CMD_W_DEF-1:0] CMD_NOP = '0;

endpackage

// File: rtl/simple_bus_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N. Returns one-hot grant, its index and a valid flag.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] k;
    idx = '0;
    any = 1'b0;
    k   = ptr;
    for (int i = 0; i < N; i++) begin
      if (!any && req[k]) begin
        any = 1'b1;
        idx = k;
      end
      k = (k == IW'(N - 1)) ? '0 : k + 1'b1;
    end
  end

  assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/simple_bus_arb.sv
// Round-robin arbiter sharing one simple_bus command port between
// NUM_REQ requesters; one command in flight, done-or-timeout completion.
module simple_bus_arb
  import simple_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = CMD_W_DEF,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       cmpl,
  output logic [NUM_REQ-1:0]       err,
  output logic                     bus_en,
  output logic [CMD_W-1:0]         bus_cmd,
  input  logic                     bus_done,
  input  logic                     bus_stall,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t              state, state_nx;
  logic [IW-1:0]       ptr, ptr_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [NUM_REQ-1:0]  gnt_nx, cmpl_nx, err_nx;
  logic                bus_en_nx, busy_nx;
  logic [CMD_W-1:0]    bus_cmd_nx;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    cnt_nx     = cnt;
    gnt_nx     = gnt;
    cmpl_nx    = '0;
    err_nx     = '0;
    bus_en_nx  = 1'b0;
    bus_cmd_nx = bus_cmd;
    busy_nx    = busy;
    unique case (state)
      IDLE: begin
        if (pick_any && !bus_stall) begin
          gnt_nx     = pick_gnt;
          bus_en_nx  = 1'b1;
          bus_cmd_nx = req_cmd[pick_idx*CMD_W +: CMD_W];
          busy_nx    = 1'b1;
          ptr_nx     = (pick_idx == IW'(NUM_REQ - 1)) ?
                       '0 : pick_idx + 1'b1;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        // done takes priority over an expiring timeout
        if (bus_done) begin
          cmpl_nx  = gnt;
          gnt_nx   = '0;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else if (cnt == CNT_MAX) begin
          err_nx   = gnt;
          gnt_nx   = '0;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      cmpl    <= '0;
      err     <= '0;
      bus_en  <= 1'b0;
      bus_cmd <= CMD_W'(CMD_NOP);
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
      gnt     <= gnt_nx;
      cmpl    <= cmpl_nx;
      err     <= err_nx;
      bus_en  <= bus_en_nx;
      bus_cmd <= bus_cmd_nx;
      busy    <= busy_nx;
    end
  end

endmodule

// File: tb/tb_simple_bus_arb.sv
// Self-checking bench for simple_bus_arb against a transaction-level
// round-robin model with randomized requests, commands and done delays.
module tb_simple_bus_arb;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 32;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_cmd;
  logic [N-1:0]   gnt, cmpl, err;
  logic           bus_en;
  logic [W-1:0]   bus_cmd;
  logic           bus_done, bus_stall, busy;

  int checks = 0;
  int errors = 0;
  int rr     = 0;

  always #5 clk = ~clk;

  simple_bus_arb #(
    .NUM_REQ(N),
    .CMD_W(W),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .req(req),
    .req_cmd(req_cmd),
    .gnt(gnt),
    .cmpl(cmpl),
    .err(err),
    .bus_en(bus_en),
    .bus_cmd(bus_cmd),
    .bus_done(bus_done),
    .bus_stall(bus_stall),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (r[IW'(j)]) return j;
    end
    return -1;
  endfunction

  // d: WAIT cycles before done is driven (-1 = never, forces timeout)
  task automatic do_txn(input logic [N-1:0] r, input logic [N*W-1:0] cmds,
                        input int d, input bit drop, input string tag);
    int           win;
    logic [N-1:0] oh;
    logic [W-1:0] cmd;
    logic [N-1:0] z;
    z   = '0;
    win = pick(r);
    oh  = N'(1) << win;
    cmd = cmds[win*W +: W];
    req = r;
    req_cmd = cmds;
    bus_stall = 1'b0;
    bus_done  = 1'b0;
    step();
    checks++;
    if ({gnt, bus_en, bus_cmd, busy, cmpl, err} !==
        {oh, 1'b1, cmd, 1'b1, z, z}) begin
      errors++;
      $display("FAIL %s_grant got gnt=%b en=%b cmd=%h busy=%b cmpl=%b err=%b exp gnt=%b cmd=%h",
               tag, gnt, bus_en, bus_cmd, busy, cmpl, err, oh, cmd);
    end
    rr = (win + 1) % N;
    if (drop) req = '0;
    req_cmd   = (N*W)'($urandom);
    bus_done  = 1'($urandom);
    bus_stall = 1'($urandom);
    step();
    checks++;
    if ({gnt, bus_en, bus_cmd, busy, cmpl, err} !==
        {oh, 1'b0, cmd, 1'b1, z, z}) begin
      errors++;
      $display("FAIL %s_issue got gnt=%b en=%b cmd=%h busy=%b cmpl=%b err=%b exp gnt=%b cmd=%h",
               tag, gnt, bus_en, bus_cmd, busy, cmpl, err, oh, cmd);
    end
    for (int w = 0; w < TO; w++) begin
      bus_done  = (w == d);
      bus_stall = 1'($urandom);
      step();
      checks++;
      if (w == d) begin
        if ({gnt, bus_en, bus_cmd, busy, cmpl, err} !==
            {z, 1'b0, cmd, 1'b0, oh, z}) begin
          errors++;
          $display("FAIL %s_done w=%0d got gnt=%b busy=%b cmpl=%b err=%b cmd=%h exp cmpl=%b",
                   tag, w, gnt, busy, cmpl, err, bus_cmd, oh);
        end
        break;
      end else if (w == TO - 1) begin
        if ({gnt, bus_en, bus_cmd, busy, cmpl, err} !==
            {z, 1'b0, cmd, 1'b0, z, oh}) begin
          errors++;
          $display("FAIL %s_timeout got gnt=%b busy=%b cmpl=%b err=%b cmd=%h exp err=%b",
                   tag, gnt, busy, cmpl, err, bus_cmd, oh);
        end
      end else begin
        if ({gnt, bus_en, bus_cmd, busy, cmpl, err} !==
            {oh, 1'b0, cmd, 1'b1, z, z}) begin
          errors++;
          $display("FAIL %s_wait w=%0d got gnt=%b en=%b busy=%b cmpl=%b err=%b exp gnt=%b",
                   tag, w, gnt, bus_en, busy, cmpl, err, oh);
        end
      end
    end
    bus_done  = 1'b0;
    bus_stall = 1'b0;
    req       = '0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    req = '0;
    req_cmd = '0;
    bus_done = 1'b0;
    bus_stall = 1'b0;
    #12;
    checks++;
    if ({gnt, cmpl, err, bus_en, bus_cmd, busy} !== '0) begin
      errors++;
      $display("FAIL reset got gnt=%b cmpl=%b err=%b en=%b cmd=%h busy=%b exp all 0",
               gnt, cmpl, err, bus_en, bus_cmd, busy);
    end
    @(negedge clk);
    rst_ = 1'b1;
    rr = 0;
    step();
  endtask

  task automatic test_fairness();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pick(4'b1111) != exp_order[i]) begin
        errors++;
        $display("FAIL fair_order i=%0d got %0d exp %0d",
                 i, pick(4'b1111), exp_order[i]);
      end
      do_txn(4'b1111, (N*W)'($urandom), 0, 1'b0, "fair");
    end
  endtask

  task automatic test_single();
    do_txn(4'b0010, 16'h0090, 2, 1'b0, "single");
    step();
    checks++;
    if ({gnt, busy, cmpl, err, bus_en} !== '0) begin
      errors++;
      $display("FAIL single_after got gnt=%b busy=%b cmpl=%b err=%b en=%b exp all 0",
               gnt, busy, cmpl, err, bus_en);
    end
  endtask

  task automatic test_stall();
    req = 4'b0001;
    req_cmd = (N*W)'($urandom);
    bus_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({bus_en, gnt, busy} !== '0) begin
        errors++;
        $display("FAIL stall_hold i=%0d got en=%b gnt=%b busy=%b exp 0",
                 i, bus_en, gnt, busy);
      end
    end
    do_txn(4'b0001, (N*W)'($urandom), 1, 1'b0, "stall_release");
  endtask

  task automatic test_timeout();
    do_txn(4'b0100, (N*W)'($urandom), -1, 1'b0, "timeout");
    do_txn(4'b0100, (N*W)'($urandom), TO - 1, 1'b0, "late_done");
  endtask

  task automatic test_noise();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      bus_done = 1'b1;
      step();
      checks++;
      if ({cmpl, err, gnt, busy, bus_en} !== '0) begin
        errors++;
        $display("FAIL idle_done got cmpl=%b err=%b gnt=%b busy=%b en=%b exp 0",
                 cmpl, err, gnt, busy, bus_en);
      end
    end
    bus_done = 1'b0;
    do_txn(4'b0110, (N*W)'($urandom), 3, 1'b1, "req_drop");
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    req_cmd = 16'h000a;
    step();
    req = '0;
    step();
    step();
    step();
    #2;
    rst_ = 1'b0;
    #1;
    checks++;
    if ({gnt, cmpl, err, bus_en, bus_cmd, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset got gnt=%b cmpl=%b err=%b en=%b cmd=%h busy=%b exp 0",
               gnt, cmpl, err, bus_en, bus_cmd, busy);
    end
    bus_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({gnt, cmpl, err, busy} !== '0) begin
        errors++;
        $display("FAIL reset_hold got gnt=%b cmpl=%b err=%b busy=%b exp 0",
                 gnt, cmpl, err, busy);
      end
    end
    bus_done = 1'b0;
    rst_ = 1'b1;
    rr = 0;
    step();
    do_txn(4'b1000, (N*W)'($urandom), 0, 1'b0, "post_reset");
    do_txn(4'b1111, (N*W)'($urandom), 1, 1'b0, "post_reset_wrap");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic [N-1:0] r;
      int s, d;
      r = N'($urandom_range(1, (1 << N) - 1));
      s = $urandom_range(0, 3);
      d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      req = r;
      bus_stall = 1'b1;
      for (int i = 0; i < s; i++) begin
        step();
        checks++;
        if ({bus_en, gnt} !== '0) begin
          errors++;
          $display("FAIL rand_stall t=%0d got en=%b gnt=%b exp 0",
                   t, bus_en, gnt);
        end
      end
      do_txn(r, (N*W)'($urandom), d, 1'($urandom), "rand");
    end
    step();
    checks++;
    if ({cmpl, err, busy, gnt} !== '0) begin
      errors++;
      $display("FAIL rand_end got cmpl=%b err=%b busy=%b gnt=%b exp 0",
               cmpl, err, busy, gnt);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_stall();
    test_timeout();
    test_noise();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
